// File: rtl/btb_predict_sa.sv
// btb_predict_sa: set-associative branch target buffer with per-entry saturating
// direction counters, two combinational fetch lookup ports and one update port.
// After reset an init sequencer clears one set per cycle before the table goes live.
// Optional same-cycle forwarding of the update to the lookup ports: BTB_BYPASS_EN.
module btb_predict_sa #(
  parameter int unsigned PC_W    = 13,
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned WAYS    = 2,
  parameter int unsigned CNT_W   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             ready,
  input  logic [PC_W-1:0]  pc1,
  input  logic [PC_W-1:0]  pc2,
  output logic             hit1,
  output logic             hit2,
  output logic [PC_W-1:0]  pre_pc1,
  output logic [PC_W-1:0]  pre_pc2,
  output logic [CNT_W-1:0] state1,
  output logic [CNT_W-1:0] state2,
  input  logic             upd_en,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_taken
);

  localparam int unsigned Sets = 2 ** INDEX_W;
  localparam int unsigned TagW = PC_W - INDEX_W;
  localparam int unsigned WayW = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CNT_W-1:0] CntWnt = CNT_W'((2 ** (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CntWt  = CNT_W'(2 ** (CNT_W - 1));
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] init_idx_q, init_idx_d;
  logic               ready_q;

  // Table storage; valid bits and victim pointers are cleared by the init sequencer.
  logic               valid_q  [Sets][WAYS];
  logic [TagW-1:0]    tag_q    [Sets][WAYS];
  logic [PC_W-1:0]    target_q [Sets][WAYS];
  logic [CNT_W-1:0]   cnt_q    [Sets][WAYS];
  logic [WayW-1:0]    victim_q [Sets];

  logic               live;
  logic               init_clr;
  logic               upd_fire;
  logic [INDEX_W-1:0] upd_set;
  logic [TagW-1:0]    upd_tag;
  logic               upd_match;
  logic [WayW-1:0]    upd_match_way;
  logic               inv_found;
  logic [WayW-1:0]    inv_way;
  logic [CNT_W-1:0]   upd_cnt_cur;
  logic [CNT_W-1:0]   upd_cnt_new;
  logic               upd_write;
  logic               wr_en;
  logic [WayW-1:0]    wr_way;
  logic               vic_adv;
  logic [WayW-1:0]    vic_next;

  logic [1:0][PC_W-1:0]  lk_pc;
  logic [1:0]            lk_hit;
  logic [1:0][PC_W-1:0]  lk_pre;
  logic [1:0][CNT_W-1:0] lk_state;

  // Reset takes effect combinationally on the outputs so nothing leaks during RST.
  assign live     = ready_q & ~RST;
  assign ready    = live;
  assign init_clr = (state_q == StInit) & ~RST;
  assign upd_fire = live & upd_en;
  assign upd_set  = upd_pc[INDEX_W-1:0];
  assign upd_tag  = upd_pc[PC_W-1:INDEX_W];

  // Init sequencer next state: walk every set once, then go live.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    case (state_q)
      StInit: begin
        init_idx_d = init_idx_q + INDEX_W'(1);
        if (init_idx_q == INDEX_W'(Sets - 1)) begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // FSM state and registered ready flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StInit;
      init_idx_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ready_q    <= (state_d == StRun);
    end
  end

  // Update decode: find the matching way, the first free way and the new counter.
  always_comb begin
    upd_match     = 1'b0;
    upd_match_way = '0;
    inv_found     = 1'b0;
    inv_way       = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[upd_set][w] && (tag_q[upd_set][w] == upd_tag)) begin
        upd_match     = 1'b1;
        upd_match_way = WayW'(w);
      end
    end
    // Descending scan so the lowest-numbered invalid way wins.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[upd_set][w]) begin
        inv_found = 1'b1;
        inv_way   = WayW'(w);
      end
    end
    upd_cnt_cur = cnt_q[upd_set][upd_match_way];
    if (upd_match) begin
      if (upd_taken) begin
        upd_cnt_new = (upd_cnt_cur == CntMax) ? upd_cnt_cur : upd_cnt_cur + CNT_W'(1);
      end else begin
        upd_cnt_new = (upd_cnt_cur == '0) ? upd_cnt_cur : upd_cnt_cur - CNT_W'(1);
      end
    end else begin
      upd_cnt_new = CntWt;
    end
    // A not-taken miss leaves the table untouched.
    upd_write = upd_match | upd_taken;
    wr_en     = upd_fire & upd_write;
    if (upd_match) begin
      wr_way = upd_match_way;
    end else if (inv_found) begin
      wr_way = inv_way;
    end else begin
      wr_way = victim_q[upd_set];
    end
    vic_adv  = ~upd_match & ~inv_found;
    vic_next = (WAYS > 1) ? victim_q[upd_set] + WayW'(1) : '0;
  end

  // Table writes: init clears take the port while the sequencer runs.
  always_ff @(posedge CLK) begin
    if (init_clr) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid_q[init_idx_q][w] <= 1'b0;
      end
      victim_q[init_idx_q] <= '0;
    end else if (wr_en) begin
      valid_q[upd_set][wr_way] <= 1'b1;
      tag_q[upd_set][wr_way]   <= upd_tag;
      cnt_q[upd_set][wr_way]   <= upd_cnt_new;
      if (upd_taken) begin
        target_q[upd_set][wr_way] <= upd_target;
      end
      if (vic_adv) begin
        victim_q[upd_set] <= vic_next;
      end
    end
  end

  assign lk_pc[0] = pc1;
  assign lk_pc[1] = pc2;

  // Per-port lookup from stored state, optionally overridden by the in-flight update.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lk_hit[p]   = 1'b0;
      lk_pre[p]   = '0;
      lk_state[p] = CntWnt;
      if (live) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (valid_q[lk_pc[p][INDEX_W-1:0]][w] &&
              (tag_q[lk_pc[p][INDEX_W-1:0]][w] == lk_pc[p][PC_W-1:INDEX_W])) begin
            lk_hit[p]   = cnt_q[lk_pc[p][INDEX_W-1:0]][w][CNT_W-1];
            lk_pre[p]   = cnt_q[lk_pc[p][INDEX_W-1:0]][w][CNT_W-1] ?
                          target_q[lk_pc[p][INDEX_W-1:0]][w] : '0;
            lk_state[p] = cnt_q[lk_pc[p][INDEX_W-1:0]][w];
          end
        end
`ifdef BTB_BYPASS_EN
        if (upd_en && upd_write && (lk_pc[p] == upd_pc)) begin
          lk_hit[p]   = upd_cnt_new[CNT_W-1];
          lk_pre[p]   = upd_cnt_new[CNT_W-1] ? upd_target : '0;
          lk_state[p] = upd_cnt_new;
        end
`endif
      end
    end
  end

  assign hit1    = lk_hit[0];
  assign hit2    = lk_hit[1];
  assign pre_pc1 = lk_pre[0];
  assign pre_pc2 = lk_pre[1];
  assign state1  = lk_state[0];
  assign state2  = lk_state[1];

endmodule

// File: tb/tb_btb_predict_sa.sv
// Self-checking bench for btb_predict_sa: directed scenarios with literal
// expectations plus a randomized run against a behavioural table model.
module tb_btb_predict_sa;

  localparam int PC_W    = 13;
  localparam int INDEX_W = 6;
  localparam int WAYS    = 2;
  localparam int CNT_W   = 2;
  localparam int SETS    = 64;
  localparam int CMAX    = 3;
  localparam int WNT     = 1;
  localparam int WT      = 2;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ready;
  logic [PC_W-1:0]  pc1 = '0, pc2 = '0;
  logic             hit1, hit2;
  logic [PC_W-1:0]  pre_pc1, pre_pc2;
  logic [CNT_W-1:0] state1, state2;
  logic             upd_en = 1'b0;
  logic [PC_W-1:0]  upd_pc = '0, upd_target = '0;
  logic             upd_taken = 1'b0;

  btb_predict_sa #(.PC_W(PC_W), .INDEX_W(INDEX_W), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ready(ready),
    .pc1(pc1), .pc2(pc2), .hit1(hit1), .hit2(hit2),
    .pre_pc1(pre_pc1), .pre_pc2(pre_pc2), .state1(state1), .state2(state2),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model of the table.
  bit m_live = 1'b0;
  bit mv   [SETS][WAYS];
  int mtag [SETS][WAYS];
  int mtgt [SETS][WAYS];
  int mcnt [SETS][WAYS];
  int mvic [SETS];

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
      mvic[s] = 0;
    end
  endfunction

  function automatic void model_update(int pc, int tgt, bit tk);
    int s, t, hw;
    s = pc % SETS;
    t = pc / SETS;
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (mv[s][w] && mtag[s][w] == t) hw = w;
    if (hw >= 0) begin
      if (tk) begin
        mcnt[s][hw] = (mcnt[s][hw] < CMAX) ? mcnt[s][hw] + 1 : CMAX;
        mtgt[s][hw] = tgt;
      end else if (mcnt[s][hw] > 0) begin
        mcnt[s][hw] = mcnt[s][hw] - 1;
      end
    end else if (tk) begin
      for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) hw = w;
      if (hw < 0) begin
        hw = mvic[s];
        mvic[s] = (mvic[s] + 1) % WAYS;
      end
      mv[s][hw]   = 1'b1;
      mtag[s][hw] = t;
      mtgt[s][hw] = tgt;
      mcnt[s][hw] = WT;
    end
  endfunction

  // {hit, pre_pc, state} seen from the stored model contents.
  function automatic logic [PC_W+CNT_W:0] model_look(int pc);
    int s, t;
    logic [PC_W+CNT_W:0] r;
    r = {1'b0, PC_W'(0), CNT_W'(WNT)};
    if (!m_live) return r;
    s = pc % SETS;
    t = pc / SETS;
    for (int w = 0; w < WAYS; w++) begin
      if (mv[s][w] && mtag[s][w] == t) begin
        if (mcnt[s][w] >= WT) r = {1'b1, PC_W'(mtgt[s][w]), CNT_W'(mcnt[s][w])};
        else r = {1'b0, PC_W'(0), CNT_W'(mcnt[s][w])};
      end
    end
    return r;
  endfunction

  // Expected port result, including forwarding of the in-flight update when enabled.
  function automatic logic [PC_W+CNT_W:0] exp_port(int pc);
    logic [PC_W+CNT_W:0] r;
    bit bypass;
    bit sv [WAYS];
    int st [WAYS], sg [WAYS], sc [WAYS], svic, s;
`ifdef BTB_BYPASS_EN
    bypass = m_live && upd_en && (pc == int'(upd_pc));
`else
    bypass = 1'b0;
`endif
    if (!bypass) return model_look(pc);
    s = pc % SETS;
    for (int w = 0; w < WAYS; w++) begin
      sv[w] = mv[s][w]; st[w] = mtag[s][w]; sg[w] = mtgt[s][w]; sc[w] = mcnt[s][w];
    end
    svic = mvic[s];
    model_update(int'(upd_pc), int'(upd_target), upd_taken);
    r = model_look(pc);
    for (int w = 0; w < WAYS; w++) begin
      mv[s][w] = sv[w]; mtag[s][w] = st[w]; mtgt[s][w] = sg[w]; mcnt[s][w] = sc[w];
    end
    mvic[s] = svic;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    if (m_live && upd_en && !RST) model_update(int'(upd_pc), int'(upd_target), upd_taken);
    @(negedge CLK);
  endtask

  task automatic upd(logic [PC_W-1:0] p, logic [PC_W-1:0] t, logic tk);
    upd_en = 1'b1; upd_pc = p; upd_target = t; upd_taken = tk;
    tick();
    upd_en = 1'b0;
  endtask

  // One-cycle reset, then the init window; optionally pulses an update mid-init.
  task automatic test_reset(string nm, logic [PC_W-1:0] p1, logic [PC_W-1:0] p2, bit pulse);
    RST = 1'b1; m_live = 1'b0; upd_en = 1'b0; pc1 = p1; pc2 = p2;
    #1;
    n_vec++;
    if ({ready, hit1, hit2, pre_pc1, state1} !== {1'b0, 1'b0, 1'b0, 13'h000, 2'b01}) begin
      n_err++;
      $display("FAIL %s_in_rst: got rdy=%b h=%b%b pre=%h st=%b want 0 00 000 01",
               nm, ready, hit1, hit2, pre_pc1, state1);
    end
    tick();
    RST = 1'b0;
    model_clear();
    for (int i = 0; i < SETS; i++) begin
      if (pulse && i == 10) begin
        upd_en = 1'b1; upd_pc = 13'h040; upd_target = 13'h100; upd_taken = 1'b1;
      end else begin
        upd_en = 1'b0;
      end
      #1;
      n_vec++;
      if ({ready, hit1, hit2, pre_pc1, pre_pc2, state1, state2} !==
          {1'b0, 1'b0, 1'b0, 13'h000, 13'h000, 2'b01, 2'b01}) begin
        n_err++;
        $display("FAIL %s_init[%0d]: got rdy=%b h=%b%b st=%b%b want rdy=0 h=00 st=0101",
                 nm, i, ready, hit1, hit2, state1, state2);
      end
      tick();
    end
    upd_en = 1'b0;
    m_live = 1'b1;
    #1;
    n_vec++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready: got %b want 1", nm, ready);
    end
  endtask

  task automatic test_alloc_sat();
    logic [CNT_W-1:0] want;
    test_reset("alloc_rst", 13'h040, 13'h000, 1'b0);
    upd(13'h040, 13'h100, 1'b1);
    pc1 = 13'h040; #1;
    n_vec++;
    if ({hit1, pre_pc1, state1} !== {1'b1, 13'h100, 2'b10}) begin
      n_err++;
      $display("FAIL alloc: got %b/%h/%b want 1/100/10", hit1, pre_pc1, state1);
    end
    for (int k = 0; k < 3; k++) begin
      upd(13'h040, 13'h100, 1'b1);
      want = 2'b11;
      #1;
      n_vec++;
      if ({hit1, pre_pc1, state1} !== {1'b1, 13'h100, want}) begin
        n_err++;
        $display("FAIL sat[%0d]: got %b/%h/%b want 1/100/11", k, hit1, pre_pc1, state1);
      end
    end
  endtask

  task automatic test_decrement();
    logic [CNT_W-1:0] want;
    test_reset("dec_rst", 13'h040, 13'h000, 1'b0);
    upd(13'h040, 13'h100, 1'b1);
    for (int k = 0; k < 4; k++) begin
      upd(13'h040, 13'h100, 1'b0);
      want = (k == 0) ? 2'b01 : 2'b00;
      #1;
      n_vec++;
      if ({hit1, pre_pc1, state1} !== {1'b0, 13'h000, want}) begin
        n_err++;
        $display("FAIL dec[%0d]: got %b/%h/%b want 0/000/%b", k, hit1, pre_pc1, state1, want);
      end
    end
  endtask

  task automatic test_replacement();
    test_reset("repl_rst", 13'h040, 13'h000, 1'b0);
    upd(13'h040, 13'h100, 1'b1);
    upd(13'h080, 13'h200, 1'b1);
    upd(13'h0C0, 13'h300, 1'b1);
    pc1 = 13'h040; pc2 = 13'h080; #1;
    n_vec++;
    if ({hit1, state1, hit2, pre_pc2} !== {1'b0, 2'b01, 1'b1, 13'h200}) begin
      n_err++;
      $display("FAIL repl_evict1: got %b/%b %b/%h want 0/01 1/200", hit1, state1, hit2, pre_pc2);
    end
    // Dual port: both slots hit different ways of the same set.
    pc1 = 13'h080; pc2 = 13'h0C0; #1;
    n_vec++;
    if ({hit1, pre_pc1, hit2, pre_pc2} !== {1'b1, 13'h200, 1'b1, 13'h300}) begin
      n_err++;
      $display("FAIL dual_port: got %b/%h %b/%h want 1/200 1/300", hit1, pre_pc1, hit2, pre_pc2);
    end
    upd(13'h100, 13'h400, 1'b1);
    pc1 = 13'h080; pc2 = 13'h100; #1;
    n_vec++;
    if ({hit1, state1, hit2, pre_pc2} !== {1'b0, 2'b01, 1'b1, 13'h400}) begin
      n_err++;
      $display("FAIL repl_evict2: got %b/%b %b/%h want 0/01 1/400", hit1, state1, hit2, pre_pc2);
    end
    pc1 = 13'h0C0; #1;
    n_vec++;
    if ({hit1, pre_pc1} !== {1'b1, 13'h300}) begin
      n_err++;
      $display("FAIL repl_keep: got %b/%h want 1/300", hit1, pre_pc1);
    end
  endtask

  task automatic test_mid_reset();
    test_reset("mid_rst", 13'h0C0, 13'h100, 1'b1);
    pc1 = 13'h040; pc2 = 13'h0C0; #1;
    n_vec++;
    if ({hit1, state1, hit2, state2} !== {1'b0, 2'b01, 1'b0, 2'b01}) begin
      n_err++;
      $display("FAIL mid_rst_drop: got %b/%b %b/%b want 0/01 0/01", hit1, state1, hit2, state2);
    end
  endtask

  task automatic test_bypass();
    test_reset("byp_rst", 13'h040, 13'h000, 1'b0);
    upd_en = 1'b1; upd_pc = 13'h040; upd_target = 13'h100; upd_taken = 1'b1;
    pc1 = 13'h040; #1;
    n_vec++;
`ifdef BTB_BYPASS_EN
    if ({hit1, pre_pc1, state1} !== {1'b1, 13'h100, 2'b10}) begin
      n_err++;
      $display("FAIL bypass_same: got %b/%h/%b want 1/100/10", hit1, pre_pc1, state1);
    end
`else
    if ({hit1, pre_pc1, state1} !== {1'b0, 13'h000, 2'b01}) begin
      n_err++;
      $display("FAIL bypass_same: got %b/%h/%b want 0/000/01", hit1, pre_pc1, state1);
    end
`endif
    tick();
    upd_en = 1'b0; #1;
    n_vec++;
    if ({hit1, pre_pc1, state1} !== {1'b1, 13'h100, 2'b10}) begin
      n_err++;
      $display("FAIL bypass_next: got %b/%h/%b want 1/100/10", hit1, pre_pc1, state1);
    end
  endtask

  function automatic logic [PC_W-1:0] rand_pc();
    return PC_W'($urandom_range(0, 5) * SETS + $urandom_range(0, 2));
  endfunction

  task automatic test_random();
    logic [2*(PC_W+CNT_W+1):0] exp_v, obs_v;
    test_reset("rand_rst", 13'h000, 13'h000, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      upd_en     = ($urandom_range(0, 3) != 0);
      upd_pc     = rand_pc();
      upd_target = PC_W'($urandom);
      upd_taken  = ($urandom_range(0, 2) != 0);
      pc1 = ($urandom_range(0, 3) == 0) ? upd_pc : rand_pc();
      pc2 = ($urandom_range(0, 3) == 0) ? pc1 : rand_pc();
      #1;
      exp_v = {m_live, exp_port(int'(pc1)), exp_port(int'(pc2))};
      obs_v = {ready, hit1, pre_pc1, state1, hit2, pre_pc2, state2};
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL random[%0d]: pc1=%h pc2=%h upd=%b/%h/%h/%b got %h want %h",
                 i, pc1, pc2, upd_en, upd_pc, upd_target, upd_taken, obs_v, exp_v);
      end
      tick();
    end
    upd_en = 1'b0;
  endtask

  initial begin
    @(negedge CLK);
    test_reset("reset", 13'h040, 13'h040, 1'b0);
    test_alloc_sat();
    test_decrement();
    test_replacement();
    test_mid_reset();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/btb_predict_sa.md
Name: btb_predict_sa

Overview:
- Parametrised, set-associative branch target buffer with per-entry saturating direction counters.
- Successor to the single-table predictor: adds configurable sets, ways and counter width, round-robin replacement, and a self-clearing init sequencer.
- Serves two fetch-stage lookup ports, one per issue slot, each combinational in the F stage.
- Takes one resolved-branch update per cycle from the branch-resolve (calcpc) stage.

Parameters:
- PC_W, 13, width of instruction PC and target.
- INDEX_W, 6, set index bits; SETS = 2**INDEX_W.
- WAYS, 2, associativity; power of two, >= 1.
- CNT_W, 2, direction counter width; >= 1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- ready  out  1  table initialised; lookups and updates are live.
- pc1  in  PC_W  slot-1 fetch PC.
- pc2  in  PC_W  slot-2 fetch PC.
- hit1  out  1  slot 1 predicted taken.
- hit2  out  1  slot 2 predicted taken.
- pre_pc1  out  PC_W  slot-1 predicted target.
- pre_pc2  out  PC_W  slot-2 predicted target.
- state1  out  CNT_W  slot-1 counter value.
- state2  out  CNT_W  slot-2 counter value.
- upd_en  in  1  resolved-branch update strobe.
- upd_pc  in  PC_W  resolved branch PC.
- upd_target  in  PC_W  resolved target.
- upd_taken  in  1  resolved direction.

Behaviour:
- Address split: index = pc[INDEX_W-1:0]; tag = pc[PC_W-1:INDEX_W].
- Entry contents: valid, tag, target, counter. Each set also holds a log2(WAYS)-bit victim pointer.
- FSM states:
  - INIT: entered on RST (takes priority in any state, including mid-INIT). Clears the valid bit and victim pointer of one set per cycle, sets 0..SETS-1 in order. Exactly SETS cycles after RST deasserts, moves to RUN.
  - RUN: ready=1. Stays in RUN until RST.
- Outputs during RST/INIT: ready=0, hit1=hit2=0, pre_pc1=pre_pc2=0, state1=state2=WNT, where WNT = 2**(CNT_W-1)-1. upd_en is ignored.
- Lookup (RUN), per port independently, combinational from stored state:
  - match = valid and tag equal in some way.
  - hit = match and counter MSB=1.
  - pre_pc = that way's target when hit, else 0.
  - state = that way's counter when matched, else WNT.
  - At most one way can match, because allocation happens only on a miss.
  - Both ports may address the same set or the same PC in one cycle.
- Update (RUN, upd_en=1), written at the clock edge:
  - Tag match, taken: counter +1, saturating at all-ones; target <= upd_target.
  - Tag match, not taken: counter -1, saturating at 0; target unchanged.
  - Miss, taken: allocate the lowest-numbered invalid way; if no way is invalid, replace the way named by the victim pointer and then advance the pointer mod WAYS. The pointer does not move when an invalid way is filled. A new entry gets valid=1, tag, target, counter = 2**(CNT_W-1) (weakly taken).
  - Miss, not taken: no state change.
- Update visibility: an update is visible to lookups from the next cycle. A same-cycle lookup sees the pre-update contents unless BTB_BYPASS_EN is defined.
- Latency: lookup 0 cycles; update 1 cycle.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- Defined: in RUN, when upd_en=1 and pcN == upd_pc, port N reports the post-update result in that same cycle:
  - hit = updated counter MSB;
  - pre_pc = upd_target if hit, else 0;
  - state = updated counter.
  - A miss with not-taken produces no bypass.
- Undefined: no forwarding; same-cycle lookups see pre-update contents.

Test Plan (default parameters):
- Init: RST=1 for 1 cycle, then 0 -> ready=0 for exactly 64 cycles, then 1. hit1=hit2=0 throughout; state1=2'b01 while pc1=0x040.
- Allocate, then reach saturation:
  - upd_en, upd_pc=0x040, upd_target=0x100, upd_taken=1 -> next cycle pc1=0x040 gives hit1=1, pre_pc1=0x100, state1=2'b10.
  - Two more taken updates -> state1=2'b11, and stays 2'b11 after a third.
- Decrement: from 2'b10, not-taken update on 0x040 -> hit1=0, pre_pc1=0, state1=2'b01. Second not-taken -> 2'b00. Further not-taken -> stays 2'b00.
- Replacement: taken updates 0x040->0x100, 0x080->0x200, 0x0C0->0x300 (all set 0) -> 0x040 misses (state=2'b01); 0x080 hits with 0x200; 0x0C0 hits with 0x300. A fourth taken update 0x100->0x400 evicts 0x080.
- Dual port: pc1=0x080, pc2=0x0C0 in the same cycle -> hit1=hit2=1, pre_pc1=0x200, pre_pc2=0x300.
- Reset mid-operation:
  - With entries present, RST for 1 cycle -> ready=0 and all lookups miss for 64 cycles.
  - upd_en pulsed during INIT is dropped: 0x040 still misses after ready=1.
- Bypass (BTB_BYPASS_EN defined): taken update 0x040->0x100 with pc1=0x040 in the same cycle -> hit1=1, pre_pc1=0x100 that cycle.
- Bypass (BTB_BYPASS_EN undefined): same stimulus -> hit1=0 that cycle, hit1=1 the next cycle.
